// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: multi-block ECB/CTR mode controller in front of a
// single-block AES core. A buffer of NBLK 128-bit blocks is taken in over a
// valid/ready handshake, fed to the core one block at a time, and returned as
// a full result buffer. The counter block is chained out through ctr_out.
module aes_mode_ctrl #(
    parameter int NBLK  = 8,
    parameter int CTR_W = 32,
    parameter int IDX_W = $clog2(NBLK) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBLK*128-1:0] in_data,
    input  logic                mode,
    input  logic [127:0]        iv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NBLK*128-1:0] out_data,
    output logic [127:0]        ctr_out,
    output logic                busy,
    output logic [IDX_W-1:0]    blk_cnt,
    output logic                core_req,
    output logic [127:0]        core_blk,
    input  logic                core_ack,
    input  logic [127:0]        core_res
);

    // Block selector is sized exactly to the buffer so indexing never
    // needs truncation; a 1-block buffer still gets a 1-bit selector.
    localparam int               SEL_W    = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NBLK - 1);
    // Bits of the counter block that take part in the increment.
    localparam logic [127:0]     CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                           : ((128'd1 << CTR_W) - 128'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [NBLK-1:0][127:0]     in_buf;
    logic [NBLK-1:0][127:0]     out_buf;
    logic                       mode_r;
    logic [127:0]               ctr_r;
    logic [127:0]               ctr_inc;
    logic [SEL_W-1:0]           sel;
    logic [127:0]               res_blk;
    logic                       accept;
    logic                       take_ack;

    assign accept   = in_valid & in_ready;
    // An ack only counts while a request is outstanding.
    assign take_ack = core_req & core_ack;
    assign busy     = (state != S_IDLE);
    assign out_data = out_buf;

    // Only the low CTR_W bits count; carries out of that field are dropped.
    assign ctr_inc  = (ctr_r & ~CTR_MASK) | ((ctr_r + 128'd1) & CTR_MASK);

    // ECB sends the plaintext block, CTR sends the counter block.
    assign core_blk = mode_r ? ctr_r : in_buf[sel];
    assign res_blk  = mode_r ? (core_res ^ in_buf[sel]) : core_res;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state and handshake/request outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        in_ready  = 1'b0;
        core_req  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Gated so nothing is accepted while reset is asserted.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_req = 1'b1;
                if (core_ack && (sel == LAST_SEL)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Plaintext capture on accept.
    always_ff @(posedge clk) begin
        // NOTE: the wide input buffer has no reset: it is always written on
        // accept before any block of it is read, so resetting it buys nothing.
        if (accept) begin
            in_buf <= in_data;
        end
    end

    // Mode, counter, block index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 1'b0;
            ctr_r   <= '0;
            sel     <= '0;
            blk_cnt <= '0;
            out_buf <= '0;
            ctr_out <= '0;
        end else if (accept) begin
            mode_r  <= mode;
            ctr_r   <= iv;
            sel     <= '0;
            blk_cnt <= '0;
        end else if (take_ack) begin
            out_buf[sel] <= res_blk;
            ctr_r        <= ctr_inc;
            blk_cnt      <= blk_cnt + IDX_W'(1);
            if (sel == LAST_SEL) begin
                ctr_out <= ctr_inc;
            end else begin
                sel <= sel + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: scoreboard bench for aes_mode_ctrl with a behavioural
// AES core stand-in (inverting or identity) whose ack delay can follow a
// 0/1/3-cycle pattern.
module tb_aes_mode_ctrl;

    localparam int NBLK  = 8;
    localparam int CTR_W = 32;
    localparam int IDX_W = $clog2(NBLK) + 1;
    localparam int W     = NBLK * 128;

    typedef struct {
        logic [W-1:0] data;
        logic [127:0] ctr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             mode = 1'b0;
    logic [127:0]     iv = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [127:0]     ctr_out;
    logic             busy;
    logic [IDX_W-1:0] blk_cnt;
    logic             core_req;
    logic [127:0]     core_blk;
    logic             core_ack;
    logic [127:0]     core_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;
    int ack_base = 0;
    exp_t sb[$];

    // Core model controls and state.
    logic core_inv = 1'b1;
    logic delay_mode = 1'b0;
    logic spur_ack = 1'b0;
    logic model_ack;
    int   wait_cnt = 0;
    int   ack_total = 0;
    int   delay_pat [3] = '{0, 1, 3};

    // core_blk stability monitor counters.
    logic         prev_wait = 1'b0;
    logic [127:0] prev_blk = '0;
    int           stab_seen = 0;
    int           stab_bad = 0;

    aes_mode_ctrl #(.NBLK(NBLK), .CTR_W(CTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .iv        (iv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ctr_out   (ctr_out),
        .busy      (busy),
        .blk_cnt   (blk_cnt),
        .core_req  (core_req),
        .core_blk  (core_blk),
        .core_ack  (core_ack),
        .core_res  (core_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: acks once the request has waited the scheduled delay.
    always_comb begin
        model_ack = core_req && (wait_cnt >= (delay_mode ? delay_pat[ack_total % 3] : 0));
    end
    assign core_ack = model_ack | spur_ack;
    assign core_res = core_inv ? ~core_blk : core_blk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (core_req) begin
            if (model_ack) begin
                wait_cnt  <= 0;
                ack_total <= ack_total + 1;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // A request left waiting in one cycle must show the same block next cycle.
    always @(negedge clk) begin
        if (rst_n && prev_wait && core_req) begin
            stab_seen <= stab_seen + 1;
            if (core_blk !== prev_blk) stab_bad <= stab_bad + 1;
        end
        prev_wait <= rst_n && core_req && !core_ack;
        prev_blk  <= core_blk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] d, input logic m,
                                   input logic [127:0] v, input logic inv);
        exp_t         e;
        logic [127:0] c;
        logic [127:0] p;
        logic [127:0] b;
        logic [127:0] r;
        c = v;
        e.data = '0;
        for (int i = 0; i < NBLK; i++) begin
            p = d[128*i +: 128];
            b = m ? c : p;
            r = inv ? ~b : b;
            e.data[128*i +: 128] = m ? (r ^ p) : r;
            c[CTR_W-1:0] = c[CTR_W-1:0] + 1'b1;
        end
        e.ctr = c;
        return e;
    endfunction

    task automatic rand_buf(output logic [W-1:0] d);
        for (int i = 0; i < W / 32; i++) d[32*i +: 32] = $urandom;
    endtask

    // Present a buffer at the current negedge and wait for acceptance.
    task automatic send(input logic [W-1:0] d, input logic m, input logic [127:0] v);
        int           n = 0;
        logic [W-1:0] junk;
        in_data  = d;
        mode     = m;
        iv       = v;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        t_acc    = cyc;
        ack_base = ack_total;
        sb.push_back(model(d, m, v, core_inv));
        @(negedge clk);
        // Inputs change after accept; the result must not depend on them.
        in_valid = 1'b0;
        rand_buf(junk);
        in_data = junk;
        mode    = ~m;
        iv      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Wait for the result, optionally hold it off, then take and score it.
    task automatic recv(input int hold, input int exp_lat);
        int           n = 0;
        exp_t         e;
        logic [W-1:0] snap;
        while (out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%b, required 1", out_valid);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (cyc - t_acc != exp_lat) begin
                errors++;
                $display("FAIL latency: got %0d cycles, required %0d", cyc - t_acc, exp_lat);
            end
        end
        checks++;
        if (blk_cnt !== IDX_W'(NBLK)) begin
            errors++;
            $display("FAIL done_blk_cnt: got %0d, required %0d", blk_cnt, NBLK);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_flags: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        snap = out_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: out_valid=%b in_ready=%b data_held=%b, required 1 0 1",
                         out_valid, in_ready, out_data === snap);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: result with no expected entry");
        end else begin
            e = sb.pop_front();
            checks++;
            if (out_data !== e.data) begin
                errors++;
                $display("FAIL out_data: got %h, required %h", out_data, e.data);
            end
            checks++;
            if (ctr_out !== e.ctr) begin
                errors++;
                $display("FAIL ctr_out: got %h, required %h", ctr_out, e.ctr);
            end
        end
        checks++;
        if (ack_total - ack_base != NBLK) begin
            errors++;
            $display("FAIL ack_count: got %0d acks, required %0d", ack_total - ack_base, NBLK);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_drop: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || core_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%b core_req=%b busy=%b, required 0 0 0",
                     out_valid, core_req, busy);
        end
        checks++;
        if (blk_cnt !== '0) begin
            errors++;
            $display("FAIL reset_blk_cnt: got %0d, required 0", blk_cnt);
        end
        checks++;
        if (out_data !== '0 || ctr_out !== '0) begin
            errors++;
            $display("FAIL reset_data: out_data_zero=%b ctr_out=%h, required 1 0",
                     out_data === '0, ctr_out);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_ecb();
        logic [W-1:0] d;
        core_inv   = 1'b1;
        delay_mode = 1'b0;
        for (int i = 0; i < NBLK; i++) d[128*i +: 128] = 128'(i);
        send(d, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        recv(0, NBLK + 1);
        checks++;
        if (out_data[128*3 +: 128] !== ~128'd3) begin
            errors++;
            $display("FAIL ecb_block3: got %h, required %h", out_data[128*3 +: 128], ~128'd3);
        end
    endtask

    task automatic test_ctr();
        core_inv   = 1'b0;
        delay_mode = 1'b0;
        send('0, 1'b1, 128'h00000000_00000000_00000000_FFFFFFFE);
        recv(0, NBLK + 1);
        checks++;
        if (out_data[127:0] !== 128'hFFFFFFFE || out_data[255:128] !== 128'hFFFFFFFF) begin
            errors++;
            $display("FAIL ctr_first_blocks: got %h %h, required FFFFFFFE FFFFFFFF",
                     out_data[127:0], out_data[255:128]);
        end
        checks++;
        if (out_data[128*2 +: 128] !== 128'd0 || out_data[128*3 +: 128] !== 128'd1) begin
            errors++;
            $display("FAIL ctr_wrap_blocks: got %h %h, required 0 1",
                     out_data[128*2 +: 128], out_data[128*3 +: 128]);
        end
        checks++;
        if (ctr_out !== 128'h6) begin
            errors++;
            $display("FAIL ctr_chain: got %h, required 6", ctr_out);
        end
    endtask

    task automatic test_delay_sweep();
        logic [W-1:0] d;
        int           seen0;
        core_inv   = 1'b1;
        delay_mode = 1'b1;
        seen0      = stab_seen;
        rand_buf(d);
        send(d, 1'b0, '0);
        recv(0, -1);
        rand_buf(d);
        send(d, 1'b1, {$urandom, $urandom, $urandom, 32'hFFFFFFFC});
        recv(0, -1);
        checks++;
        if (stab_seen <= seen0) begin
            errors++;
            $display("FAIL delay_waits: got %0d wait cycles, required >0", stab_seen - seen0);
        end
        checks++;
        if (stab_bad != 0) begin
            errors++;
            $display("FAIL core_blk_stable: got %0d changes while waiting, required 0", stab_bad);
        end
        delay_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [127:0] vb;
        core_inv = 1'b1;
        rand_buf(a);
        rand_buf(b);
        vb = {$urandom, $urandom, $urandom, $urandom};
        send(a, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        in_data  = b;
        mode     = 1'b0;
        iv       = vb;
        in_valid = 1'b1;
        recv(5, NBLK + 1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_ready: got %b, required 1", in_ready);
        end
        send(b, 1'b0, vb);
        recv(0, NBLK + 1);
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] d;
        int           n = 0;
        core_inv = 1'b1;
        rand_buf(d);
        send(d, 1'b0, '0);
        while (blk_cnt !== IDX_W'(3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (blk_cnt !== IDX_W'(3)) begin
            errors++;
            $display("FAIL midop_progress: blk_cnt=%0d, required 3", blk_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (core_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_abort: core_req=%b out_valid=%b, required 0 0", core_req, out_valid);
        end
        checks++;
        if (blk_cnt !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_state: blk_cnt=%0d in_ready=%b, required 0 0", blk_cnt, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_release: in_ready=%b, required 1", in_ready);
        end
        rand_buf(d);
        send(d, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        recv(0, NBLK + 1);
    endtask

    task automatic test_spurious_ack();
        logic [W-1:0] d;
        logic [W-1:0] snap;
        int           n = 0;
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== IDX_W'(NBLK)) begin
            errors++;
            $display("FAIL spur_idle: busy=%b in_ready=%b blk_cnt=%0d, required 0 1 %0d",
                     busy, in_ready, blk_cnt, NBLK);
        end
        rand_buf(d);
        send(d, 1'b0, '0);
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap     = out_data;
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || blk_cnt !== IDX_W'(NBLK) || out_data !== snap) begin
            errors++;
            $display("FAIL spur_done: out_valid=%b blk_cnt=%0d data_held=%b, required 1 %0d 1",
                     out_valid, blk_cnt, out_data === snap, NBLK);
        end
        recv(0, -1);
    endtask

    initial begin
        test_reset();
        test_ecb();
        test_ctr();
        test_delay_sweep();
        test_backpressure();
        test_reset_midop();
        test_spurious_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Parametrised multi-block mode controller that sits in front of a single-block (128-bit) AES encryption core.
- Accepts a wide buffer of NBLK 128-bit blocks over a valid/ready handshake and feeds the blocks to the core one at a time.
- Supports ECB mode and CTR mode (keystream XOR) and returns the full result buffer over a valid/ready handshake.
- Generalises the fixed 1024-bit enc_aes datapath to any block count and adds mode selection, backpressure and counter chaining.

Parameters:
- NBLK, 8, number of 128-bit blocks per buffer; must be >= 1; default gives 1024-bit buffers.
- CTR_W, 32, width of the CTR increment field (low bits of the counter block); 1..128.
- IDX_W, $clog2(NBLK)+1, width of blk_cnt.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input buffer valid.
- in_ready  out  1  controller can accept a buffer.
- in_data  in  NBLK*128  plaintext buffer; block i = in_data[128*i+127:128*i].
- mode  in  1  0=ECB, 1=CTR; sampled on accept.
- iv  in  128  initial counter block; sampled on accept.
- out_valid  out  1  result buffer valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  NBLK*128  result buffer, same block ordering as in_data.
- ctr_out  out  128  counter value after the last block; used to chain the next buffer.
- busy  out  1  high in any state other than IDLE.
- blk_cnt  out  IDX_W  number of blocks completed in the current buffer.
- core_req  out  1  request to the AES core.
- core_blk  out  128  block presented to the core.
- core_ack  in  1  core done; one pulse per request.
- core_res  in  128  core ciphertext; valid when core_ack=1.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN: core_req=1.
  - DONE: out_valid=1.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=0 while rst_n is low (gated).
  - out_valid=0, core_req=0, busy=0, blk_cnt=0, out_data=0, ctr_out=0.
  - Internal counter and index registers are 0.
- IDLE -> RUN on in_valid & in_ready:
  - Latch in_data, mode and iv.
  - Counter register <= iv; index i <= 0; blk_cnt <= 0.
- RUN:
  - core_req is held high until core_ack; a core_ack while core_req is low is ignored.
  - core_blk = block i (ECB) or the counter register (CTR); it is stable while core_req is high and waiting.
  - core_ack may arrive in the same cycle core_req is high for the first time (zero-wait core).
- On core_ack in RUN:
  - Result block i <= core_res (ECB) or core_res ^ block i (CTR).
  - Counter low CTR_W bits <= (low bits + 1) mod 2^CTR_W; upper 128-CTR_W bits are unchanged. The counter increments in both modes; in ECB it is unused.
  - blk_cnt <= blk_cnt + 1.
  - If i < NBLK-1: i <= i+1, stay in RUN. core_req stays high and core_blk shows the next block in the following cycle; every ack consumes exactly one request.
  - If i == NBLK-1: go to DONE; core_req low from the next cycle; ctr_out <= incremented counter.
- DONE:
  - out_valid=1; out_data and ctr_out are stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - out_data and ctr_out hold their values until the next buffer overwrites them.
- Latency with a zero-wait core:
  - Accept at cycle T; acks at T+1..T+NBLK; out_valid at T+NBLK+1.
  - Earliest next accept: the cycle after the out_valid & out_ready handshake.
- Changes on in_data, mode or iv after accept have no effect. in_valid outside IDLE is ignored and not queued.
- Reset mid-operation aborts immediately:
  - core_req drops asynchronously.
  - The partial result is discarded and blk_cnt=0.
  - The core is expected to be reset by the same rst_n.
- NBLK=1: RUN lasts exactly until one ack, then goes to DONE.

Test Plan:
- ECB, NBLK=8, zero-wait core model with core_res=~core_blk, in_data block i = i -> out block i = ~i, out_valid exactly 9 cycles after accept, blk_cnt=8.
- CTR, CTR_W=32, iv=0x00000000_00000000_00000000_FFFFFFFE, identity core, in_data=0 -> out blocks ...FFFFFFFE, ...FFFFFFFF, ...00000000, ...00000001, ... (upper 96 bits stay 0); ctr_out low word = 0x00000006.
- Core delay sweep: ack latency 0, 1 and 3 cycles mixed per block -> core_blk stable while waiting, results identical to zero-wait run, no block skipped or duplicated.
- Backpressure: out_ready held low 5 cycles in DONE with in_valid=1 -> out_valid and out_data held, in_ready=0, second buffer accepted only after the handshake.
- Reset mid-op: rst_n low after 3 acks of 8 -> core_req=0 and out_valid=0 immediately; after release, in_ready=1 and a fresh buffer completes correctly.
- Spurious ack: core_ack pulsed in IDLE and DONE -> no state change, blk_cnt unchanged.
